// File: rtl/display_timing_ctrl.sv
// Raster timing controller: sequences external pixel/line/address counters and
// produces registered sync, blanking and frame-start signals from their values.
module display_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       ResetN,
    input  logic       Enable,
    input  logic [9:0] PxOut,
    input  logic [9:0] LineOut,
    output logic       IncPx,
    output logic       ResetPx,
    output logic       IncLine,
    output logic       ResetLine,
    output logic       IncAddr1,
    output logic       ResetAddr1,
    output logic       HSync,
    output logic       VSync,
    output logic       Blank,
    output logic       FrameStart
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEGIN = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEGIN = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] w_px;
    logic [31:0] w_ln;
    logic        w_active;
    logic        w_out_of_range;
    logic        w_line_end;
    logic        w_frame_end;
    logic        w_visible;

    assign w_px           = 32'(PxOut);
    assign w_ln           = 32'(LineOut);
    assign w_active       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    // Counter values past the raster are handled as a frame wrap so the
    // scan recovers within one cycle.
    assign w_out_of_range = (w_px >= H_TOTAL) || (w_ln >= V_TOTAL);
    assign w_line_end     = (w_px == H_TOTAL - 1);
    assign w_frame_end    = (w_line_end && (w_ln == V_TOTAL - 1)) || w_out_of_range;
    assign w_visible      = (w_px < H_ACTIVE) && (w_ln < V_ACTIVE);

    always_ff @(posedge clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        IncPx      = 1'b0;
        ResetPx    = 1'b0;
        IncLine    = 1'b0;
        ResetLine  = 1'b0;
        IncAddr1   = 1'b0;
        ResetAddr1 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ResetPx    = 1'b1;
                ResetLine  = 1'b1;
                ResetAddr1 = 1'b1;
                if (Enable) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                ResetPx    = 1'b1;
                ResetLine  = 1'b1;
                ResetAddr1 = 1'b1;
                w_next     = Enable ? ST_RUN : ST_IDLE;
            end
            ST_RUN, ST_DRAIN: begin
                if (w_frame_end) begin
                    ResetPx    = 1'b1;
                    ResetLine  = 1'b1;
                    ResetAddr1 = 1'b1;
                end else if (w_line_end) begin
                    ResetPx = 1'b1;
                    IncLine = 1'b1;
                end else begin
                    IncPx    = 1'b1;
                    IncAddr1 = w_visible;
                end
                // DRAIN keeps scanning until the frame closes; Enable pulls it back to RUN.
                if (r_state == ST_RUN) begin
                    if (!Enable) begin
                        w_next = w_frame_end ? ST_IDLE : ST_DRAIN;
                    end
                end else begin
                    if (Enable) begin
                        w_next = ST_RUN;
                    end else if (w_frame_end) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next     = ST_IDLE;
                ResetPx    = 1'b1;
                ResetLine  = 1'b1;
                ResetAddr1 = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge ResetN) begin
        if (!ResetN) begin
            HSync      <= 1'b1;
            VSync      <= 1'b1;
            Blank      <= 1'b1;
            FrameStart <= 1'b0;
        end else begin
            HSync      <= !((w_px >= HS_BEGIN) && (w_px < HS_END));
            VSync      <= !((w_ln >= VS_BEGIN) && (w_ln < VS_END));
            Blank      <= (w_px >= H_ACTIVE) || (w_ln >= V_ACTIVE) || !w_active;
            FrameStart <= w_active && (PxOut == '0) && (LineOut == '0);
        end
    end

endmodule
